// File: rtl/vdec1_pkg.sv
// rtl/vdec1_pkg.sv - shared types and constants for the vdec1 CRC checker
package vdec1_pkg;

    localparam int              CRC_W         = 16;
    localparam logic [CRC_W-1:0] CRC_POLY      = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT_DFLT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/vdec1_crc16.sv
// rtl/vdec1_crc16.sv - one-bit serial CRC-16 step, non-reflected
module vdec1_crc16
    import vdec1_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
    input  logic [CRC_W-1:0] crc_reg_i,
    input  logic             crc_in_i,
    output logic [CRC_W-1:0] crc_next_o
);

    logic fb;

    // Shift left one bit and fold in the polynomial when the feedback bit is set
    always_comb begin
        fb         = crc_reg_i[CRC_W-1] ^ crc_in_i;
        crc_next_o = {crc_reg_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/vdec1_crc_chk.sv
// rtl/vdec1_crc_chk.sv - serial block CRC-16 checker; VDEC1_CRC_ERRCNT_EN adds a failure counter
module vdec1_crc_chk
    import vdec1_pkg::*;
#(
    parameter int               LEN_W    = 13,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_start,
    input  logic [LEN_W-1:0] blk_len,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             busy,
    output logic             crc_done,
    output logic             crc_pass
`ifdef VDEC1_CRC_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    state_e           state_q;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_next;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             last_data;
    logic             last_crc;

    vdec1_crc16 #(
        .POLY (CRC_POLY)
    ) u_crc16 (
        .crc_reg_i  (crc_q),
        .crc_in_i   (bit_in),
        .crc_next_o (crc_next)
    );

    // Terminal-count decodes for the payload and CRC phases
    always_comb begin
        last_data = (cnt_q == (len_q - LEN_W'(1)));
        last_crc  = (cnt_q == LEN_W'(CRC_W - 1));
    end

    // Block state machine; blk_start from any state (re)opens a block and masks bit_vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (blk_start) begin
                len_q  <= blk_len;
                crc_q  <= CRC_INIT;
                cnt_q  <= '0;
                busy_q <= 1'b1;
                state_q <= (blk_len == '0) ? ST_CRC : ST_DATA;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_DATA: begin
                        if (bit_vld) begin
                            crc_q <= crc_next;
                            if (last_data) begin
                                cnt_q   <= '0;
                                state_q <= ST_CRC;
                            end else begin
                                cnt_q <= cnt_q + LEN_W'(1);
                            end
                        end
                    end
                    ST_CRC: begin
                        if (bit_vld) begin
                            crc_q <= crc_next;
                            if (last_crc) begin
                                // Result is registered on entry so it is visible during DONE
                                cnt_q   <= '0;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                pass_q  <= (crc_next == '0);
                            end else begin
                                cnt_q <= cnt_q + LEN_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign crc_done = done_q;
    assign crc_pass = pass_q;

`ifdef VDEC1_CRC_ERRCNT_EN
    logic [15:0] err_q;

    // Saturating count of failed blocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (done_q && !pass_q && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_vdec1_crc_chk.sv
// tb/tb_vdec1_crc_chk.sv - directed self-checking bench for vdec1_crc_chk
module tb_vdec1_crc_chk;

    logic        clk;
    logic        rst_n;
    logic        blk_start;
    logic [12:0] blk_len;
    logic        bit_vld;
    logic        bit_in;
    logic        busy;
    logic        crc_done;
    logic        crc_pass;
`ifdef VDEC1_CRC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int n_chk;
    int n_fail;
    int done_cnt;
    int busy_drop;
    int d0;

    logic [71:0] msg;
    localparam logic [15:0] GOOD_CRC = 16'h31C3;
    localparam logic [15:0] BAD_CRC  = 16'h31C2;

    vdec1_crc_chk dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_start (blk_start),
        .blk_len   (blk_len),
        .bit_vld   (bit_vld),
        .bit_in    (bit_in),
        .busy      (busy),
        .crc_done  (crc_done),
        .crc_pass  (crc_pass)
`ifdef VDEC1_CRC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (crc_done === 1'b1) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse with a coincident bit_vld that must be ignored
    task automatic start_blk(input logic [12:0] len);
        blk_start = 1'b1;
        blk_len   = len;
        bit_vld   = 1'b1;
        bit_in    = 1'b1;
        tick();
        blk_start = 1'b0;
        bit_vld   = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit gapped);
        if (gapped) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 99) < 30) begin
                    bit_vld = 1'b0;
                    tick();
                    if (busy !== 1'b1) busy_drop++;
                end
            end
        end
        bit_vld = 1'b1;
        bit_in  = b;
        tick();
        bit_vld = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit gapped);
        for (int i = 0; i < n; i++) send_bit(msg[71-i], gapped);
    endtask

    // Sends 16 CRC bits MSB-first; crc_done must stay low until the 16th
    task automatic send_crc(input logic [15:0] c, input bit gapped);
        for (int i = 0; i < 15; i++) send_bit(c[15-i], gapped);
        check("pre_last_crc_done", {31'd0, crc_done}, 32'd0);
        send_bit(c[0], gapped);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        done_cnt  = 0;
        busy_drop = 0;
        msg       = "123456789";
        rst_n     = 1'b0;
        blk_start = 1'b0;
        blk_len   = '0;
        bit_vld   = 1'b0;
        bit_in    = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, crc_done}, 32'd0);
        check("rst_pass", {31'd0, crc_pass}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Good block: result one cycle after last bit
        d0 = done_cnt;
        start_blk(13'd72);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_msg(72, 1'b0);
        send_crc(GOOD_CRC, 1'b0);
        check("t1_done", {31'd0, crc_done}, 32'd1);
        check("t1_pass", {31'd0, crc_pass}, 32'd1);
        tick();
        check("t1_done_clr", {31'd0, crc_done}, 32'd0);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_one_done", done_cnt - d0, 32'd1);

        // Corrupted CRC bit 0
        start_blk(13'd72);
        send_msg(72, 1'b0);
        send_crc(BAD_CRC, 1'b0);
        check("t2_done", {31'd0, crc_done}, 32'd1);
        check("t2_pass", {31'd0, crc_pass}, 32'd0);
        tick();
`ifdef VDEC1_CRC_ERRCNT_EN
        check("t2_err_cnt", {16'd0, err_cnt}, 32'd1);
`endif

        // Empty payload: exactly 16 CRC bits
        start_blk(13'd0);
        send_crc(16'h0000, 1'b0);
        check("t4_done", {31'd0, crc_done}, 32'd1);
        check("t4_pass", {31'd0, crc_pass}, 32'd1);
        tick();

        // Bad block then gapped good block
        start_blk(13'd72);
        send_msg(72, 1'b0);
        send_crc(BAD_CRC, 1'b0);
        check("t3_pre_pass", {31'd0, crc_pass}, 32'd0);
        tick();
        busy_drop = 0;
        start_blk(13'd72);
        send_msg(72, 1'b1);
        send_crc(GOOD_CRC, 1'b1);
        check("t3_done", {31'd0, crc_done}, 32'd1);
        check("t3_pass", {31'd0, crc_pass}, 32'd1);
        check("t3_busy_held", busy_drop, 32'd0);
        tick();

        // Abort at payload bit 40 then full block
        d0 = done_cnt;
        start_blk(13'd72);
        send_msg(40, 1'b0);
        start_blk(13'd72);
        send_msg(72, 1'b0);
        send_crc(GOOD_CRC, 1'b0);
        check("t5_pass", {31'd0, crc_pass}, 32'd1);
        tick();
        check("t5_one_done", done_cnt - d0, 32'd1);

        // Bad block, restart in DONE with an empty good block
        start_blk(13'd72);
        send_msg(72, 1'b0);
        send_crc(BAD_CRC, 1'b0);
        check("t6_done", {31'd0, crc_done}, 32'd1);
        check("t6_fail", {31'd0, crc_pass}, 32'd0);
        start_blk(13'd0);
        check("t6_restart_busy", {31'd0, busy}, 32'd1);
        check("t6_done_clr", {31'd0, crc_done}, 32'd0);
        send_crc(16'h0000, 1'b0);
        check("t6_done2", {31'd0, crc_done}, 32'd1);
        check("t6_pass2", {31'd0, crc_pass}, 32'd1);
        tick();

        // Reset at CRC bit 8
        start_blk(13'd72);
        send_msg(72, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(GOOD_CRC[15-i], 1'b0);
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", {31'd0, busy}, 32'd0);
        check("t7_rst_done", {31'd0, crc_done}, 32'd0);
        check("t7_rst_pass", {31'd0, crc_pass}, 32'd0);
        tick();
        rst_n = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) send_bit(GOOD_CRC[7-i], 1'b0);
        repeat (12) tick();
        check("t7_no_done", done_cnt - d0, 32'd0);
        check("t7_idle", {31'd0, busy}, 32'd0);
        start_blk(13'd72);
        send_msg(72, 1'b0);
        send_crc(GOOD_CRC, 1'b0);
        check("t7_done", {31'd0, crc_done}, 32'd1);
        check("t7_pass", {31'd0, crc_pass}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
